// File: rtl/spi_fl_arbiter.sv
// spi_fl_arbiter
// Two-requester round-robin arbiter/sequencer in front of the SPI flash master.
// Requester 0 is the CPU CSR path and requester 1 is the XIP/boot read path.
// The arbiter grants one request, latches its descriptor, issues it to the master
// with a validflag/tready handshake, waits for completion, and then returns the
// read data to the granted requester as a one-cycle response pulse.
// Optional feature: define SPI_FL_ARB_WDOG_EN to enable a watchdog. The watchdog
// aborts a transfer after WDOG_CYC cycles and responds with rsp_err=1 and
// rsp_data=32'hDEAD_DEAD.
module spi_fl_arbiter #(
    parameter int DESC_W   = 102,
    parameter int WDOG_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [DESC_W-1:0] req_desc0,
    input  logic [DESC_W-1:0] req_desc1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              m_validflag,
    output logic [DESC_W-1:0] m_desc,
    input  logic              m_tready,
    input  logic [31:0]       m_data_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_gnt;
    logic              r_rr_last;
    logic [DESC_W-1:0] r_desc;
    logic [31:0]       r_rsp_data;
    logic              w_gnt;
    logic              w_grant_en;
    logic              w_capture;
    logic              w_abort;
    logic              w_timeout;

    // Round-robin pick: a lone requester always wins; on a tie, the requester
    // that was not served last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
        w_gnt = 1'b0;
        case (req_valid)
            2'b01:   w_gnt = 1'b0;
            2'b10:   w_gnt = 1'b1;
            2'b11:   w_gnt = ~r_rr_last;
            default: w_gnt = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next      = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        m_validflag = 1'b0;
        w_grant_en  = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready[w_gnt] = 1'b1;
                    w_grant_en       = 1'b1;
                    w_next           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Validflag is held for as long as the master stalls; an accept beats a timeout.
                m_validflag = 1'b1;
                if (m_tready) begin
                    w_next = ST_WAIT_ACK;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_RESP;
                end
            end
            ST_WAIT_ACK: begin
                // The master drops tready one cycle after accept; that marks it as busy.
                if (!m_tready) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                if (m_tready) begin
                    w_capture = 1'b1;
                    w_next    = ST_RESP;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[r_gnt] = 1'b1;
                w_next           = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, descriptor latch, and response data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt      <= 1'b0;
            r_rr_last  <= 1'b1;
            r_desc     <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_grant_en) begin
                r_gnt     <= w_gnt;
                r_rr_last <= w_gnt;
                r_desc    <= w_gnt ? req_desc1 : req_desc0;
            end
            if (w_capture) begin
                r_rsp_data <= m_data_out;
            end else if (w_abort) begin
                r_rsp_data <= 32'hDEAD_DEAD;
            end
        end
    end

`ifdef SPI_FL_ARB_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);

    logic [15:0] r_wdog_cnt;
    logic        r_rsp_err;

    // Watchdog counter: cleared on the grant edge (entry to ISSUE), counts while a transfer is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= '0;
        end else if (w_grant_en) begin
            r_wdog_cnt <= '0;
        end else if (r_state == ST_ISSUE || r_state == ST_WAIT_ACK || r_state == ST_WAIT_DONE) begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end

    // Error flag for the pending response: set by an abort, cleared by a normal completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_abort) begin
            r_rsp_err <= 1'b1;
        end else if (w_capture) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign w_timeout = (r_wdog_cnt == WDOG_LAST);
    assign rsp_err   = r_rsp_err && (r_state == ST_RESP);
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign busy     = (r_state != ST_IDLE);
    assign m_desc   = r_desc;
    assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_spi_fl_arbiter.sv
// tb_spi_fl_arbiter
// Directed bench for spi_fl_arbiter. A procedural flash-master model drives
// m_tready/m_data_out. All expected values are hand-derived constants.
module tb_spi_fl_arbiter;

    localparam int DESC_W = 102;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [DESC_W-1:0] req_desc0;
    logic [DESC_W-1:0] req_desc1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              m_validflag;
    logic [DESC_W-1:0] m_desc;
    logic              m_tready;
    logic [31:0]       m_data_out;

    int n_total = 0;
    int n_bad   = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;

    localparam logic [DESC_W-1:0] DESC_A = {6'h2A, 10'h155, 4'h3, 7'h20, 32'hCAFE_0001, 32'h0000_1000, 3'h1, 8'h03};
    localparam logic [DESC_W-1:0] DESC_B = {6'h15, 10'h0AA, 4'h8, 7'h40, 32'hBEEF_0002, 32'h00FF_2000, 3'h5, 8'hEB};

    spi_fl_arbiter #(.DESC_W(DESC_W), .WDOG_CYC(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_desc0   (req_desc0),
        .req_desc1   (req_desc1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .m_validflag (m_validflag),
        .m_desc      (m_desc),
        .m_tready    (m_tready),
        .m_data_out  (m_data_out)
    );

    always #5 clk = ~clk;

    // Count handshake accepts and response pulses as seen by the DUT on each edge.
    always @(posedge clk) begin
        if (m_validflag && m_tready) acc_cnt <= acc_cnt + 1;
        if (rsp_valid != 2'b00)      rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  128'(busy), 128'(0));
        check({tag, "_vf"},    128'(m_validflag), 128'(0));
        check({tag, "_desc"},  128'(m_desc), 128'(0));
        check({tag, "_rdy"},   128'(req_ready), 128'(0));
        check({tag, "_rspv"},  128'(rsp_valid), 128'(0));
        check({tag, "_rspd"},  128'(rsp_data), 128'(0));
        check({tag, "_rspe"},  128'(rsp_err), 128'(0));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        m_tready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full transaction. Entered in the low phase with req_valid driven and the DUT in IDLE.
    // Returns in the low phase of the first IDLE cycle after the response.
    task automatic do_txn(input string tag, input logic [1:0] exp_g, input logic [DESC_W-1:0] exp_desc,
                          input int stall, input int lat, input logic [31:0] data, input logic drop);
        int acc0;
        int vf_lo;
        int early;
        acc0  = acc_cnt;
        vf_lo = 0;
        early = 0;
        if (stall > 0) m_tready = 1'b0;
        #1;
        check({tag, "_ready"}, 128'(req_ready), 128'(exp_g));
        @(negedge clk);
        if (drop) req_valid = 2'b00;
        check({tag, "_issue_vf"}, 128'(m_validflag), 128'(1));
        check({tag, "_desc"}, 128'(m_desc), 128'(exp_desc));
        check({tag, "_ready_pulse"}, 128'(req_ready), 128'(0));
        repeat (stall) begin
            @(negedge clk);
            if (!m_validflag) vf_lo++;
        end
        check({tag, "_vf_held"}, 128'(vf_lo), 128'(0));
        m_tready = 1'b1;
        @(negedge clk);
        check({tag, "_vf_drop"}, 128'(m_validflag), 128'(0));
        m_tready = 1'b0;
        repeat (lat - 1) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) early++;
        end
        check({tag, "_no_early_rsp"}, 128'(early), 128'(0));
        m_data_out = data;
        m_tready   = 1'b1;
        @(negedge clk);
        check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(exp_g));
        check({tag, "_rsp_data"}, 128'(rsp_data), 128'(data));
        check({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        check({tag, "_desc_stable"}, 128'(m_desc), 128'(exp_desc));
        m_data_out = 32'h5555_AAAA;
        @(negedge clk);
        check({tag, "_rsp_once"}, 128'(rsp_valid), 128'(0));
        check({tag, "_rsp_hold"}, 128'(rsp_data), 128'(data));
        check({tag, "_idle"}, 128'(busy), 128'(0));
        check({tag, "_one_accept"}, 128'(acc_cnt - acc0), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int rsp0;
        int busy_lo;
        int waited;
        logic [1:0] exp_g;
        req_desc0  = DESC_A;
        req_desc1  = DESC_B;
        m_data_out = 32'h0;
        @(negedge clk);
        do_reset();
        check_idle_outputs("reset");

        // Single requester 0, long master latency.
        req_valid = 2'b01;
        do_txn("t2", 2'b01, DESC_A, 0, 40, 32'h1234_5678, 1'b1);

        // Master stalls in ISSUE for 10 cycles.
        req_valid = 2'b01;
        do_txn("t4", 2'b01, DESC_A, 10, 3, 32'h0BAD_F00D, 1'b1);

        // Reset while stalled in ISSUE.
        req_valid = 2'b01;
        m_tready  = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t1_rst");
        rst      = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);

        // Both requesters held: grants alternate 0,1,0,1 from reset.
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            do_txn($sformatf("t3_%0d", i), exp_g, (i % 2 == 0) ? DESC_A : DESC_B,
                   0, 2 + i, 32'hA000_0000 + 32'(i), 1'b0);
        end
        // Withdraw before the grant edge: nothing happens.
        req_valid = 2'b00;
        @(negedge clk);
        check("withdraw_idle", 128'(busy), 128'(0));

        // Reset during WAIT_DONE, then a normal requester-1 transfer.
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        m_tready = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_in_flight", 128'(busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_rst");
        rst      = 1'b0;
        m_tready = 1'b1;
        rsp0     = rsp_cnt;
        repeat (5) @(negedge clk);
        check("t5_no_rsp", 128'(rsp_cnt - rsp0), 128'(0));
        req_valid = 2'b10;
        do_txn("t5_req1", 2'b10, DESC_B, 0, 6, 32'h7777_1111, 1'b1);

        // Master never raises tready.
        req_valid = 2'b01;
        m_tready  = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
`ifdef SPI_FL_ARB_WDOG_EN
        waited = 0;
        while (rsp_valid == 2'b00 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("t6_wdog_rsp_valid", 128'(rsp_valid), 128'(2'b01));
        check("t6_wdog_err", 128'(rsp_err), 128'(1));
        check("t6_wdog_data", 128'(rsp_data), 128'(32'hDEAD_DEAD));
`else
        rsp0    = rsp_cnt;
        busy_lo = 0;
        waited  = 0;
        repeat (150) begin
            @(negedge clk);
            waited++;
            if (!busy) busy_lo++;
        end
        check("t6_busy_held", 128'(busy_lo), 128'(0));
        check("t6_no_rsp", 128'(rsp_cnt - rsp0), 128'(0));
        check("t6_vf_held", 128'(m_validflag), 128'(1));
`endif
        do_reset();
        check_idle_outputs("final_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
